// File: rtl/rom_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : rom_io_responder
// Purpose  : ROM-side end of the MCS-4 bus (4001-style). Follows the 8-phase
//            instruction cycle, serves instruction bytes and a 4-bit I/O port.
// Revision : 1.0
// ============================================================================
module rom_io_responder #(
    parameter logic [3:0] CHIP_ID  = 4'h0,
    parameter logic [3:0] IO_RESET = 4'h0
) (
    input  logic       sysclk,
    input  logic       poc_n,
    input  logic       clk1,
    input  logic       clk2,
    input  logic       sync,
    input  logic       cmrom,
    input  logic [3:0] data_in,
    output logic [3:0] data_out,
    output logic       data_oe,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic [3:0] io_in,
    output logic [3:0] io_out
);

    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    localparam logic [3:0] C_OPR_SRC = 4'h2;
    localparam logic [3:0] C_OPR_IO  = 4'hE;
    localparam logic [3:0] C_OPA_WRR = 4'h2;
    localparam logic [3:0] C_OPA_RDR = 4'hA;

    logic [2:0] r_phase;
    logic [2:0] w_phase_next;
    logic       r_synced;

    logic       r_chip_sel;
    logic       r_io_sel;
    logic       r_io_op;
    logic [3:0] r_opr;
    logic [3:0] r_opa;
    logic [7:0] r_rom_addr;
    logic [3:0] r_io_out;
    logic [3:0] r_data_out;
    logic       r_data_oe;

    logic       w_phase_edge;
    logic       w_sample;
    logic       w_chip_match;
    logic       w_oe_next;
    logic [3:0] w_dout_next;
    logic       w_unused_clk1;

    // clk2 alone defines the phase edge, so an overlapping clk1 has no effect
    assign w_phase_edge  = clk2;
    assign w_unused_clk1 = clk1;
    assign w_sample      = w_phase_edge & r_synced;
    assign w_chip_match  = (data_in == CHIP_ID) & cmrom & r_synced;

    // ------------------------------------------------------------------
    // Phase state register
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
            r_phase  <= PH_X3;
            r_synced <= 1'b0;
        end else if (w_phase_edge) begin
            r_phase <= w_phase_next;
            if (sync) begin
                r_synced <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next phase: X3 + 1 wraps naturally to A1; sync forces A1 from anywhere
    // ------------------------------------------------------------------
    always_comb begin
        w_phase_next = r_phase + 3'd1;
        if (sync) begin
            w_phase_next = PH_A1;
        end
    end

    // ------------------------------------------------------------------
    // Bus drive for the phase being entered; a resync always enters A1,
    // which never drives, so an abandoned cycle produces no drive.
    // ------------------------------------------------------------------
    always_comb begin
        w_oe_next   = 1'b0;
        w_dout_next = r_data_out;
        if (!sync) begin
            case (r_phase)
                PH_A3: begin
                    if (w_chip_match) begin
                        w_oe_next   = 1'b1;
                        w_dout_next = rom_data[7:4];
                    end
                end
                PH_M1: begin
                    if (r_chip_sel) begin
                        w_oe_next   = 1'b1;
                        w_dout_next = rom_data[3:0];
                    end
                end
                PH_X1: begin
                    if (r_io_op && (r_opa == C_OPA_RDR)) begin
                        w_oe_next   = 1'b1;
                        w_dout_next = io_in;
                    end
                end
                default: begin
                    w_oe_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
            r_data_oe  <= 1'b0;
            r_data_out <= 4'h0;
        end else if (w_phase_edge) begin
            r_data_oe  <= w_oe_next;
            r_data_out <= w_dout_next;
        end
    end

    // ------------------------------------------------------------------
    // Bus sampling at the edge that ends each phase; inert until first sync
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
            r_rom_addr <= 8'h00;
            r_chip_sel <= 1'b0;
            r_opr      <= 4'h0;
            r_opa      <= 4'h0;
            r_io_op    <= 1'b0;
            r_io_sel   <= 1'b0;
            r_io_out   <= IO_RESET;
        end else if (w_sample) begin
            case (r_phase)
                PH_A1: r_rom_addr[3:0] <= data_in;
                PH_A2: r_rom_addr[7:4] <= data_in;
                PH_A3: r_chip_sel      <= w_chip_match;
                PH_M1: r_opr           <= data_in;
                PH_M2: begin
                    r_opa   <= data_in;
                    r_io_op <= (r_opr == C_OPR_IO) & cmrom & r_io_sel;
                end
                PH_X2: begin
                    // SRC is opr 2 with odd opa; even opa is FIM and is ignored
                    if (cmrom && (r_opr == C_OPR_SRC) && r_opa[0]) begin
                        r_io_sel <= (data_in == CHIP_ID);
                    end
                    if (r_io_op && (r_opa == C_OPA_WRR)) begin
                        r_io_out <= data_in;
                    end
                end
                default: begin
                    r_io_op <= r_io_op;
                end
            endcase
        end
    end

    assign data_out = r_data_out;
    assign data_oe  = r_data_oe;
    assign rom_addr = r_rom_addr;
    assign io_out   = r_io_out;

endmodule
`default_nettype wire
